toggle_dec: RTL and testbench

TOGGLE_DEC -- requirements
Module: toggle_dec

---
 rtl/toggle_dec.sv | 91 +++++++++
 tb/tb_toggle_dec.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/toggle_dec.sv
// Toggle-encoded event decoder with a pending-event counter and a sticky overflow flag.
// Define TOGGLE_DEC_SYNC_EN to put a two-flop synchronizer on tin.
module toggle_dec #(
    parameter int CW = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          tin,
    input  logic          evt_ready,
    input  logic          ovf_clr,
    output logic          pulse,
    output logic          evt_valid,
    output logic [CW-1:0] pend_cnt,
    output logic          ovf
);

    localparam logic [CW-1:0] CNT_MAX = '1;
    localparam logic [CW-1:0] CNT_ONE = {{(CW-1){1'b0}}, 1'b1};

    logic          samp_d, samp_q;
    logic          h_d, h_q;
    logic          pulse_d, pulse_q;
    logic [CW-1:0] cnt_d, cnt_q;
    logic          ovf_d, ovf_q;
    logic          pop;
    logic          ovf_set;

`ifdef TOGGLE_DEC_SYNC_EN
    logic sync1_q, sync2_q;

    // Sync flops load tin on reset so a level held through reset is not an edge.
    always_ff @(negedge clk) begin
        if (reset) begin
            sync1_q <= tin;
            sync2_q <= tin;
        end else begin
            sync1_q <= tin;
            sync2_q <= sync1_q;
        end
    end

    assign samp_d = sync2_q;
`else
    assign samp_d = tin;
`endif

    assign h_d       = samp_q;
    assign pulse_d   = samp_q ^ h_q;
    assign pop       = evt_valid & evt_ready;
    assign evt_valid = (cnt_q != '0);

    always_comb begin
        cnt_d   = cnt_q;
        ovf_set = 1'b0;
        unique case ({pulse_q, pop})
            2'b10: begin
                if (cnt_q == CNT_MAX) begin
                    ovf_set = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            2'b01:   cnt_d = cnt_q - CNT_ONE;
            default: cnt_d = cnt_q;
        endcase
    end

    // A fresh overflow beats a clear on the same edge.
    assign ovf_d = ovf_set | (ovf_q & ~ovf_clr);

    always_ff @(negedge clk) begin
        if (reset) begin
            samp_q  <= tin;
            h_q     <= tin;
            pulse_q <= 1'b0;
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            samp_q  <= samp_d;
            h_q     <= h_d;
            pulse_q <= pulse_d;
            cnt_q   <= cnt_d;
            ovf_q   <= ovf_d;
        end
    end

    assign pulse    = pulse_q;
    assign pend_cnt = cnt_q;
    assign ovf      = ovf_q;

endmodule

// File: tb/tb_toggle_dec.sv
// Bench for toggle_dec: directed scenarios plus random traffic against
// an event-scheduling reference model.
module tb_toggle_dec;

`ifdef TOGGLE_DEC_SYNC_EN
    localparam int D = 3;
`else
    localparam int D = 1;
`endif
    localparam int MAXC = 15;

    logic       clk;
    logic       reset;
    logic       tin;
    logic       evt_ready;
    logic       ovf_clr;
    logic       pulse;
    logic       evt_valid;
    logic [3:0] pend_cnt;
    logic       ovf;

    int vecs = 0;
    int errs = 0;
    logic t = 1'b1;

    toggle_dec #(.CW(4)) dut (
        .clk      (clk),
        .reset    (reset),
        .tin      (tin),
        .evt_ready(evt_ready),
        .ovf_clr  (ovf_clr),
        .pulse    (pulse),
        .evt_valid(evt_valid),
        .pend_cnt (pend_cnt),
        .ovf      (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: a tin change seen at edge n yields a pulse
    // after edge n+D; the counter follows the pulse/pop rules.
    int   cyc = 0;
    int   due[$];
    logic m_last = 1'b0;
    logic m_pulse = 1'b0;
    int   m_cnt = 0;
    logic m_ovf = 1'b0;

    always @(negedge clk) begin
        bit pop, lost;
        cyc++;
        if (reset) begin
            m_pulse = 1'b0;
            m_cnt   = 0;
            m_ovf   = 1'b0;
            due.delete();
            m_last  = tin;
        end else begin
            pop  = (m_cnt != 0) && evt_ready;
            lost = 1'b0;
            if (m_pulse && !pop) begin
                if (m_cnt == MAXC) lost = 1'b1;
                else m_cnt++;
            end else if (!m_pulse && pop) begin
                m_cnt--;
            end
            if (lost) m_ovf = 1'b1;
            else if (ovf_clr) m_ovf = 1'b0;
            m_pulse = 1'b0;
            if (due.size() > 0 && due[0] == cyc) begin
                m_pulse = 1'b1;
                void'(due.pop_front());
            end
            if (tin !== m_last) begin
                due.push_back(cyc + D);
                m_last = tin;
            end
        end
    end

    function automatic logic [6:0] expv();
        return {m_pulse, m_cnt != 0, 4'(m_cnt), m_ovf};
    endfunction

    // Drive one cycle of inputs and advance past one sampling edge.
    task automatic run(input logic ti, input logic rd,
                       input logic cl, input logic rs);
        tin       = ti;
        evt_ready = rd;
        ovf_clr   = cl;
        reset     = rs;
        @(posedge clk);
    endtask

    task automatic test_reset();
        for (int i = 0; i < 15; i++) begin
            run(1'b1, 1'b0, 1'b0, i < 5);
            vecs++;
            if (pulse !== 1'b0 || pend_cnt !== 4'd0 ||
                evt_valid !== 1'b0 || ovf !== 1'b0) begin
                errs++;
                $display("FAIL reset cyc%0d: got p=%b c=%0d v=%b o=%b want 0/0/0/0",
                         i, pulse, pend_cnt, evt_valid, ovf);
            end
        end
        t = 1'b1;
    endtask

    task automatic test_single();
        int np = 0;
        for (int i = 0; i < 12 + D + 2; i++) begin
            if (i < 12 && i % 4 == 0) t = ~t;
            run(t, 1'b0, 1'b0, 1'b0);
            np += int'(pulse);
            vecs++;
            if ({pulse, evt_valid, pend_cnt, ovf} !== expv()) begin
                errs++;
                $display("FAIL single cyc%0d: got %b want %b",
                         i, {pulse, evt_valid, pend_cnt, ovf}, expv());
            end
        end
        vecs++;
        if (np !== 3 || pend_cnt !== 4'd3 || evt_valid !== 1'b1) begin
            errs++;
            $display("FAIL single_end: got pulses=%0d cnt=%0d v=%b want 3/3/1",
                     np, pend_cnt, evt_valid);
        end
    endtask

    task automatic test_consume();
        int ec;
        for (int i = 0; i < 5; i++) begin
            run(t, 1'b1, 1'b0, 1'b0);
            ec = (i < 3) ? 2 - i : 0;
            vecs++;
            if (pend_cnt !== 4'(ec) || evt_valid !== (ec != 0)) begin
                errs++;
                $display("FAIL consume cyc%0d: got cnt=%0d v=%b want %0d/%b",
                         i, pend_cnt, evt_valid, ec, ec != 0);
            end
        end
    endtask

    task automatic test_toggles(input int n, input int gap);
        for (int i = 0; i < n * gap + D + 2; i++) begin
            if (i < n * gap && i % gap == 0) t = ~t;
            run(t, 1'b0, 1'b0, 1'b0);
            vecs++;
            if ({pulse, evt_valid, pend_cnt, ovf} !== expv()) begin
                errs++;
                $display("FAIL toggles cyc%0d: got %b want %b",
                         i, {pulse, evt_valid, pend_cnt, ovf}, expv());
            end
        end
    endtask

    task automatic test_back_to_back();
        int run_len = 0, best = 0;
        for (int i = 0; i < 13 + D + 2; i++) begin
            if (i < 13) t = ~t;
            run(t, 1'b0, 1'b0, 1'b0);
            run_len = pulse ? run_len + 1 : 0;
            if (run_len > best) best = run_len;
        end
        vecs++;
        if (best !== 13 || pend_cnt !== 4'd15 || ovf !== 1'b0) begin
            errs++;
            $display("FAIL back_to_back: got run=%0d cnt=%0d ovf=%b want 13/15/0",
                     best, pend_cnt, ovf);
        end
    endtask

    task automatic test_simul(input int level);
        bit hit = 1'b0;
        logic rd;
        t = ~t;
        for (int k = 0; k < 10 && !hit; k++) begin
            rd = m_pulse;
            run(t, rd, 1'b0, 1'b0);
            if (rd) begin
                hit = 1'b1;
                vecs++;
                if (pend_cnt !== 4'(level) || ovf !== 1'b0) begin
                    errs++;
                    $display("FAIL simul_%0d: got cnt=%0d ovf=%b want %0d/0",
                             level, pend_cnt, ovf, level);
                end
            end
        end
        vecs++;
        if (!hit) begin
            errs++;
            $display("FAIL simul_%0d_timeout: got no pulse want pulse", level);
        end
        run(t, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_overflow();
        int np = 0;
        bit seen = 1'b0;
        logic rd;
        run(t, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 17 + D + 2; i++) begin
            if (i < 17) t = ~t;
            run(t, 1'b0, 1'b0, 1'b0);
            if (ovf && !seen) begin
                seen = 1'b1;
                vecs++;
                if (np !== 16) begin
                    errs++;
                    $display("FAIL ovf_onset: got after %0d pulses want 16", np);
                end
            end
            np += int'(pulse);
        end
        vecs++;
        if (pend_cnt !== 4'd15 || ovf !== 1'b1) begin
            errs++;
            $display("FAIL ovf_full: got cnt=%0d ovf=%b want 15/1", pend_cnt, ovf);
        end
        run(t, 1'b0, 1'b1, 1'b0);
        vecs++;
        if (ovf !== 1'b0) begin
            errs++;
            $display("FAIL ovf_clr: got %b want 0", ovf);
        end
        t = ~t;
        for (int k = 0; k < 10; k++) begin
            rd = m_pulse;
            run(t, 1'b0, rd, 1'b0);
            if (rd) break;
        end
        run(t, 1'b0, 1'b0, 1'b0);
        vecs++;
        if (ovf !== 1'b1 || pend_cnt !== 4'd15) begin
            errs++;
            $display("FAIL ovf_set_wins: got ovf=%b cnt=%0d want 1/15", ovf, pend_cnt);
        end
    endtask

    task automatic test_midreset();
        for (int i = 0; i < 10; i++) run(t, 1'b1, 1'b0, 1'b0);
        vecs++;
        if (pend_cnt !== 4'd5 || ovf !== 1'b1) begin
            errs++;
            $display("FAIL mid_pre: got cnt=%0d ovf=%b want 5/1", pend_cnt, ovf);
        end
        t = ~t;
        run(t, 1'b0, 1'b0, 1'b0);
        run(t, 1'b1, 1'b1, 1'b1);
        for (int i = 0; i < 8; i++) begin
            vecs++;
            if (pulse !== 1'b0 || pend_cnt !== 4'd0 || ovf !== 1'b0 ||
                evt_valid !== 1'b0) begin
                errs++;
                $display("FAIL mid_reset cyc%0d: got p=%b c=%0d o=%b v=%b want 0",
                         i, pulse, pend_cnt, ovf, evt_valid);
            end
            run(t, 1'b0, 1'b0, 1'b0);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(1, 0) == 1) t = ~t;
            run(t, $urandom_range(3, 0) == 0, $urandom_range(15, 0) == 0,
                $urandom_range(63, 0) == 0);
            vecs++;
            if ({pulse, evt_valid, pend_cnt, ovf} !== expv()) begin
                errs++;
                $display("FAIL random cyc%0d: got %b want %b",
                         i, {pulse, evt_valid, pend_cnt, ovf}, expv());
            end
        end
    endtask

    initial begin
        tin       = 1'b1;
        reset     = 1'b1;
        evt_ready = 1'b0;
        ovf_clr   = 1'b0;
        @(posedge clk);
        test_reset();
        test_single();
        test_consume();
        test_toggles(2, 3);
        test_simul(2);
        test_back_to_back();
        test_simul(15);
        test_overflow();
        test_midreset();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
